// File: rtl/rv_pkg.sv
// Shared encodings for the multi-cycle RV32I-subset core: opcodes, FSM states,
// ALU controls and immediate formats.
package rv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_WORD    = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
  } alu_op_e;

  typedef enum logic [1:0] {
    IMM_I, IMM_S, IMM_B
  } imm_fmt_e;

  function automatic logic [31:0] imm_ext(input logic [31:0] ir, input imm_fmt_e fmt);
    case (fmt)
      IMM_S:   return {{20{ir[31]}}, ir[31:25], ir[11:7]};
      IMM_B:   return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      default: return {{20{ir[31]}}, ir[31:20]};
    endcase
  endfunction

endpackage

// File: rtl/rv_multicycle_core_if.sv
// Instruction-ROM and data-RAM bus between the core (master) and memories (slave).
interface rv_multicycle_core_if #(
  parameter int unsigned XLEN = 8,
  parameter int unsigned AW   = 8
);
  logic [AW-1:0]   imem_addr;
  logic [31:0]     imem_rdata;
  logic            dmem_we;
  logic [AW-1:0]   dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output imem_addr, dmem_we, dmem_addr, dmem_wdata,
    input  imem_rdata, dmem_rdata
  );

  modport slave (
    input  imem_addr, dmem_we, dmem_addr, dmem_wdata,
    output imem_rdata, dmem_rdata
  );
endinterface

// File: rtl/rv_regfile.sv
// Register file: x0 hard-wired to zero, x1..x(NREGS-1) stored, synchronous write,
// two combinational read ports plus a debug read port.
module rv_regfile #(
  parameter int unsigned XLEN  = 8,
  parameter int unsigned NREGS = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  input  logic [4:0]      dbg_sel,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  output logic [XLEN-1:0] dbg_data
);
  logic [XLEN-1:0] regs_q [1:NREGS-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 1; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we) begin
      for (int unsigned i = 1; i < NREGS; i++)
        if (waddr == 5'(i)) regs_q[i] <= wdata;
    end
  end

  // Indices 0 and >= NREGS never match, so they read as zero.
  always_comb begin
    rdata1   = '0;
    rdata2   = '0;
    dbg_data = '0;
    for (int unsigned i = 1; i < NREGS; i++) begin
      if (raddr1 == 5'(i))  rdata1   = regs_q[i];
      if (raddr2 == 5'(i))  rdata2   = regs_q[i];
      if (dbg_sel == 5'(i)) dbg_data = regs_q[i];
    end
  end
endmodule

// File: rtl/rv_multicycle_core.sv
// Multi-cycle RV32I-subset core: FETCH/DECODE/EXEC/MEM/WB FSM sharing one ALU,
// with run/single-step control, halt on illegal instruction and a debug read port.
module rv_multicycle_core
  import rv_pkg::*;
#(
  parameter int unsigned XLEN  = 8,
  parameter int unsigned AW    = 8,
  parameter int unsigned NREGS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 step,
  rv_multicycle_core_if.master mem,
  input  logic [4:0]           dbg_sel,
  output logic [XLEN-1:0]      dbg_data,
  output logic [AW-1:0]        pc,
  output logic [31:0]          instr,
  output logic                 instr_done,
  output logic                 zero,
  output logic                 halted
);
  state_e          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d, alu_q, alu_d, mdr_q, mdr_d;
  logic            zero_q, zero_d;

  logic            legal, use_imm, is_load, is_store, is_br;
  alu_op_e         alu_op;
  imm_fmt_e        fmt;
  logic [XLEN-1:0] op_b, alu_res, rs1_data, rs2_data;
  logic            rf_we, mem_we, done, last;

  rv_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
    .clk(clk), .rst(rst), .we(rf_we), .waddr(ir_q[11:7]),
    .wdata(is_load ? mdr_q : alu_q),
    .raddr1(ir_q[19:15]), .raddr2(ir_q[24:20]), .dbg_sel(dbg_sel),
    .rdata1(rs1_data), .rdata2(rs2_data), .dbg_data(dbg_data)
  );

  always_comb begin
    legal    = 1'b0;
    use_imm  = 1'b1;
    is_load  = 1'b0;
    is_store = 1'b0;
    is_br    = 1'b0;
    alu_op   = ALU_ADD;
    fmt      = IMM_I;
    case (ir_q[6:0])
      OP_R: begin
        use_imm = 1'b0;
        if (ir_q[31:25] == F7_BASE) begin
          legal = 1'b1;
          case (ir_q[14:12])
            F3_ADD_SUB: alu_op = ALU_ADD;
            F3_SLT:     alu_op = ALU_SLT;
            F3_OR:      alu_op = ALU_OR;
            F3_AND:     alu_op = ALU_AND;
            default:    legal  = 1'b0;
          endcase
        end else if (ir_q[31:25] == F7_SUB && ir_q[14:12] == F3_ADD_SUB) begin
          legal  = 1'b1;
          alu_op = ALU_SUB;
        end
      end
      OP_IMM:  legal = (ir_q[14:12] == F3_ADD_SUB);
      OP_LOAD: begin
        legal   = (ir_q[14:12] == F3_WORD);
        is_load = 1'b1;
      end
      OP_STORE: begin
        legal    = (ir_q[14:12] == F3_WORD);
        is_store = 1'b1;
        fmt      = IMM_S;
      end
      OP_BRANCH: begin
        legal   = (ir_q[14:12] == F3_BEQ);
        is_br   = 1'b1;
        use_imm = 1'b0;
        alu_op  = ALU_SUB;
        fmt     = IMM_B;
      end
      default: legal = 1'b0;
    endcase
  end

  assign op_b = use_imm ? imm_q : b_q;

  always_comb begin
    case (alu_op)
      ALU_SUB: alu_res = a_q - op_b;
      ALU_AND: alu_res = a_q & op_b;
      ALU_OR:  alu_res = a_q | op_b;
      ALU_SLT: alu_res = XLEN'($signed(a_q) < $signed(op_b));
      default: alu_res = a_q + op_b;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    imm_d   = imm_q;
    alu_d   = alu_q;
    mdr_d   = mdr_q;
    zero_d  = zero_q;
    rf_we   = 1'b0;
    mem_we  = 1'b0;
    done    = 1'b0;
    last    = 1'b0;
    case (state_q)
      S_IDLE:   if (run || step) state_d = S_FETCH;
      S_FETCH: begin
        ir_d    = mem.imem_rdata;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        a_d     = rs1_data;
        b_d     = rs2_data;
        imm_d   = XLEN'(imm_ext(ir_q, fmt));
        state_d = S_EXEC;
      end
      S_EXEC: begin
        alu_d  = alu_res;
        zero_d = (alu_res == '0);
        if (!legal)                   state_d = S_HALT;
        else if (is_br)               last    = 1'b1;
        else if (is_load || is_store) state_d = S_MEM;
        else                          state_d = S_WB;
      end
      S_MEM: begin
        if (is_load) begin
          mdr_d   = mem.dmem_rdata;
          state_d = S_WB;
        end else begin
          mem_we = 1'b1;
          last   = 1'b1;
        end
      end
      S_WB: begin
        rf_we = 1'b1;
        last  = 1'b1;
      end
      default: state_d = S_HALT;
    endcase
    // Shared retirement path; is_br can only be set here when retiring from EXEC.
    if (last) begin
      done    = 1'b1;
      pc_d    = (is_br && a_q == b_q) ? pc_q + AW'($signed(imm_q)) : pc_q + AW'(4);
      state_d = run ? S_FETCH : S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= run ? S_FETCH : S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
      zero_q  <= zero_d;
    end
  end

  assign mem.imem_addr  = pc_q;
  assign mem.dmem_addr  = AW'(alu_q);
  assign mem.dmem_wdata = b_q;
  assign mem.dmem_we    = mem_we & ~rst;
  assign instr_done     = done & ~rst;
  assign pc             = pc_q;
  assign instr          = ir_q;
  assign zero           = zero_q;
  assign halted         = (state_q == S_HALT);
endmodule

// File: tb/tb_rv_multicycle_core.sv
// Directed bench for rv_multicycle_core: table-driven program run plus
// hand-written step-mode, halt and reset-in-MEM sequences.
module tb_rv_multicycle_core;
  localparam int unsigned XLEN = 8, AW = 8, NREGS = 8;
  localparam int NV = 19;

  logic        clk = 1'b0;
  logic        rst, run, step, init_req;
  logic [4:0]  dbg_sel;
  logic [7:0]  dbg_data, pc;
  logic [31:0] instr;
  logic        instr_done, zero, halted;
  int          total = 0, bad = 0;
  int          done_cnt = 0, we_cnt = 0, base, web;
  logic [7:0]  we_addr = '0, we_data = '0;
  logic [31:0] rom [64];
  logic [7:0]  ram [256];

  rv_multicycle_core_if #(.XLEN(XLEN), .AW(AW)) bus ();

  rv_multicycle_core #(.XLEN(XLEN), .AW(AW), .NREGS(NREGS)) dut (
    .clk(clk), .rst(rst), .run(run), .step(step), .mem(bus),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data), .pc(pc), .instr(instr),
    .instr_done(instr_done), .zero(zero), .halted(halted)
  );

  always #5 clk = ~clk;

  assign bus.imem_rdata = rom[bus.imem_addr[7:2]];
  assign bus.dmem_rdata = ram[bus.dmem_addr];

  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'(i);
    end else if (bus.dmem_we) begin
      ram[bus.dmem_addr] <= bus.dmem_wdata;
      we_cnt  <= we_cnt + 1;
      we_addr <= bus.dmem_addr;
      we_data <= bus.dmem_wdata;
    end
    if (instr_done) done_cnt <= done_cnt + 1;
  end

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] ins;
    int          lat;
    int          rd;
    logic [7:0]  val;
    logic [7:0]  pc;
    logic        z;
  } vec_t;
  vec_t vecs [NV];

  function automatic logic [31:0] enc_r(int f7, int f3, int rd, int rs1, int rs2);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_addi(int rd, int rs1, int imm);
    return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
  endfunction
  function automatic logic [31:0] enc_lw(int rd, int rs1, int imm);
    return {12'(imm), 5'(rs1), 3'b010, 5'(rd), 7'b0000011};
  endfunction
  function automatic logic [31:0] enc_sw(int rs2, int rs1, int imm);
    logic [11:0] i;
    i = 12'(imm);
    return {i[11:5], 5'(rs2), 5'(rs1), 3'b010, i[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_beq(int rs1, int rs2, int imm);
    logic [12:0] i;
    i = 13'(imm);
    return {i[12], i[10:5], 5'(rs2), 5'(rs1), 3'b000, i[4:1], i[11], 7'b1100011};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk_reg(input string nm, input int idx, input logic [7:0] exp);
    dbg_sel = 5'(idx);
    #1;
    check(nm, 32'(dbg_data), 32'(exp));
  endtask

  task automatic do_reset(input logic r);
    rst  = 1'b1;
    run  = r;
    step = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = 32'h0;
  endtask

  initial begin
    vecs[0]  = '{8'h00, enc_addi(1, 0, 5),          4, 1, 8'h05, 8'h04, 1'b0};
    vecs[1]  = '{8'h04, enc_addi(2, 0, 3),          4, 2, 8'h03, 8'h08, 1'b0};
    vecs[2]  = '{8'h08, enc_r(0, 0, 3, 1, 2),       4, 3, 8'h08, 8'h0C, 1'b0};
    vecs[3]  = '{8'h0C, enc_r(32, 0, 4, 2, 1),      4, 4, 8'hFE, 8'h10, 1'b0};
    vecs[4]  = '{8'h10, enc_r(0, 2, 5, 4, 1),       4, 5, 8'h01, 8'h14, 1'b0};
    vecs[5]  = '{8'h14, enc_r(0, 7, 6, 1, 2),       4, 6, 8'h01, 8'h18, 1'b0};
    vecs[6]  = '{8'h18, enc_r(0, 6, 7, 1, 2),       4, 7, 8'h07, 8'h1C, 1'b0};
    vecs[7]  = '{8'h1C, enc_sw(3, 0, 4),            4, 3, 8'h08, 8'h20, 1'b0};
    vecs[8]  = '{8'h20, enc_lw(6, 0, 4),            5, 6, 8'h08, 8'h24, 1'b0};
    vecs[9]  = '{8'h24, enc_addi(5, 0, -1),         4, 5, 8'hFF, 8'h28, 1'b0};
    vecs[10] = '{8'h28, enc_r(32, 0, 7, 1, 1),      4, 7, 8'h00, 8'h2C, 1'b1};
    vecs[11] = '{8'h2C, enc_addi(8, 0, 9),          4, 8, 8'h00, 8'h30, 1'b0};
    vecs[12] = '{8'h30, enc_addi(0, 0, 7),          4, 0, 8'h00, 8'h34, 1'b0};
    vecs[13] = '{8'h34, enc_beq(1, 2, 8),           3, 1, 8'h05, 8'h38, 1'b0};
    vecs[14] = '{8'h38, enc_beq(1, 1, 8),           3, 1, 8'h05, 8'h40, 1'b1};
    vecs[15] = '{8'h3C, 32'h0000007F,               0, 0, 8'h00, 8'h00, 1'b0};
    vecs[16] = '{8'h40, enc_r(0, 2, 4, 1, 4),       4, 4, 8'h00, 8'h44, 1'b1};
    vecs[17] = '{8'h44, enc_beq(0, 0, -72),         3, 0, 8'h00, 8'hFC, 1'b1};
    vecs[18] = '{8'hFC, enc_beq(0, 0, 8),           3, 0, 8'h00, 8'h04, 1'b1};

    clear_rom();
    for (int k = 0; k < NV; k++) rom[vecs[k].addr[7:2]] = vecs[k].ins;
    dbg_sel  = '0;
    init_req = 1'b1;
    rst = 1'b1; run = 1'b1; step = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_pc", 32'(pc), 32'h0);
    check("reset_ir", instr, 32'h0);
    check("reset_zero", 32'(zero), 32'h0);
    check("reset_halted", 32'(halted), 32'h0);
    check("reset_done", 32'(instr_done), 32'h0);
    check("reset_we", 32'(bus.dmem_we), 32'h0);
    for (int r = 1; r < 8; r++) chk_reg($sformatf("reset_x%0d", r), r, 8'h00);
    @(posedge clk);
    #1 rst = 1'b0; init_req = 1'b0;

    // Main table: vecs[15] is the skipped slot behind the taken branch.
    for (int k = 0; k < NV; k++) begin
      int lat;
      if (k == 15) continue;
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!instr_done && lat < 20);
      @(posedge clk); #1;
      check($sformatf("lat[%0d]", k), 32'(lat), 32'(vecs[k].lat));
      check($sformatf("ir[%0d]", k), instr, vecs[k].ins);
      check($sformatf("pc[%0d]", k), 32'(pc), 32'(vecs[k].pc));
      check($sformatf("zero[%0d]", k), 32'(zero), 32'(vecs[k].z));
      chk_reg($sformatf("reg[%0d]", k), vecs[k].rd, vecs[k].val);
    end
    check("sw_count", 32'(we_cnt), 32'd1);
    check("sw_addr", 32'(we_addr), 32'h04);
    check("sw_data", 32'(we_data), 32'h08);

    // Step mode, step held, run dropped mid-instruction.
    clear_rom();
    rom[0] = enc_addi(1, 0, 5);
    rom[1] = enc_addi(2, 1, 1);
    rom[2] = enc_addi(3, 2, 1);
    rom[3] = enc_addi(4, 0, 1);
    rom[4] = enc_addi(5, 0, 2);
    do_reset(1'b0);
    base = done_cnt;
    repeat (10) @(posedge clk); #1;
    check("idle_pc", 32'(pc), 32'h0);
    check("idle_done", 32'(done_cnt - base), 32'd0);
    step = 1'b1;
    @(posedge clk); #1 step = 1'b0;
    repeat (8) @(posedge clk); #1;
    check("step1_done", 32'(done_cnt - base), 32'd1);
    check("step1_pc", 32'(pc), 32'h04);
    chk_reg("step1_x1", 1, 8'h05);
    step = 1'b1;
    repeat (10) @(posedge clk); #1 step = 1'b0;
    repeat (5) @(posedge clk); #1;
    check("stephold_done", 32'(done_cnt - base), 32'd3);
    check("stephold_pc", 32'(pc), 32'h0C);
    chk_reg("stephold_x3", 3, 8'h07);
    chk_reg("stephold_x4", 4, 8'h00);
    run = 1'b1;
    repeat (2) @(posedge clk); #1 run = 1'b0;
    repeat (8) @(posedge clk); #1;
    check("rundrop_done", 32'(done_cnt - base), 32'd4);
    check("rundrop_pc", 32'(pc), 32'h10);
    chk_reg("rundrop_x4", 4, 8'h01);
    chk_reg("rundrop_x5", 5, 8'h00);

    // Illegal opcode halts with nothing committed.
    clear_rom();
    rom[0] = enc_addi(1, 0, 5);
    rom[1] = 32'h0000007F;
    rom[2] = enc_addi(2, 0, 1);
    do_reset(1'b1);
    base = done_cnt;
    web  = we_cnt;
    repeat (15) @(posedge clk); #1;
    check("halt_flag", 32'(halted), 32'h1);
    check("halt_pc", 32'(pc), 32'h04);
    check("halt_done", 32'(done_cnt - base), 32'd1);
    chk_reg("halt_x1", 1, 8'h05);
    chk_reg("halt_x2", 2, 8'h00);
    step = 1'b1;
    repeat (6) @(posedge clk); #1 step = 1'b0; run = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("halt_sticky", 32'(halted), 32'h1);
    check("halt_pc_frozen", 32'(pc), 32'h04);
    check("halt_no_done", 32'(done_cnt - base), 32'd1);
    check("halt_no_we", 32'(we_cnt - web), 32'd0);

    // Reset landing in the MEM cycle of a store.
    clear_rom();
    rom[0] = enc_addi(1, 0, 9);
    rom[1] = enc_sw(1, 0, 8);
    do_reset(1'b1);
    web = we_cnt;
    repeat (5) @(posedge clk); #1;
    chk_reg("rstmem_pre_x1", 1, 8'h09);
    repeat (2) @(posedge clk); #1 rst = 1'b1; run = 1'b0;
    @(negedge clk);
    check("rstmem_we", 32'(bus.dmem_we), 32'h0);
    repeat (2) @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("rstmem_we_cnt", 32'(we_cnt - web), 32'd0);
    check("rstmem_ram8", 32'(ram[8]), 32'h08);
    check("rstmem_pc", 32'(pc), 32'h0);
    for (int r = 1; r < 8; r++) chk_reg($sformatf("rstmem_x%0d", r), r, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
